// File: rtl/spike_seq_pkg.sv
// Shared types for the spike sample sequencer: FSM states, event codes,
// unit index type and the captured-result payload.
package spike_seq_pkg;

  localparam int unsigned UNIT_IDX_W = 2;
  localparam int unsigned EVENT_W    = 2;

  typedef logic [UNIT_IDX_W-1:0] unit_idx_t;

  typedef enum logic [2:0] {
    WAIT_MSB = 3'd0,
    WAIT_LSB = 3'd1,
    ISSUE    = 3'd2,
    PROCESS  = 3'd3,
    CAPTURE  = 3'd4
  } seq_state_e;

  typedef enum logic [EVENT_W-1:0] {
    EV_NONE = 2'b00,
    EV_1    = 2'b01,
    EV_2    = 2'b10,
    EV_3    = 2'b11
  } event_e;

  // Result captured from a unit at the end of its processing window
  typedef struct packed {
    unit_idx_t          unit;
    logic               spike;
    logic [EVENT_W-1:0] evt;
  } seq_result_t;

  // Round-robin successor, wrapping at the last populated unit
  function automatic unit_idx_t next_unit(input unit_idx_t cur, input int unsigned num_units);
    if (32'(cur) >= num_units - 1) return '0;
    return cur + unit_idx_t'(1);
  endfunction

endpackage

// File: rtl/spike_counter_bank.sv
// Per-unit saturating spike counters with synchronous clear and readback mux.
// Ports: clk, rst_n (async active-low), clr (clears all, wins over inc),
//        inc (one-hot increment), sel (readback index), cnt_out (comb mux,
//        0 when sel addresses an unpopulated unit).
module spike_counter_bank
  import spike_seq_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [NUM_UNITS-1:0] inc,
  input  unit_idx_t            sel,
  output logic [CNT_WIDTH-1:0] cnt_out
);

  logic [NUM_UNITS*CNT_WIDTH-1:0] cnt_flat;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q;

    // Saturating counter; clear takes priority over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clr) begin
        cnt_q <= '0;
      end else if (inc[g] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end

    assign cnt_flat[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  // Readback mux
  always_comb begin
    cnt_out = '0;
    if (32'(sel) < NUM_UNITS) begin
      cnt_out = CNT_WIDTH'(cnt_flat >> (32'(sel) * CNT_WIDTH));
    end
  end

endmodule

// File: rtl/spike_sample_sequencer.sv
// Front-end controller for the multi-unit spike-detection datapath.
// Assembles MSB-first byte pairs into samples, issues them round-robin to the
// detection units, waits PROCESS_CYCLES, captures each unit's spike/event
// result and keeps per-unit saturating spike counts.
// Ports: byte_in/byte_valid/byte_ready (byte stream), frame_start (restart at
//        unit 0), sample_data/unit_valid (issue to units), unit_spike/unit_event
//        (unit results), res_* (captured result strobe), cnt_sel/cnt_out
//        (counter readback), clr (clears counters and overrun), overrun
//        (sticky dropped-byte flag), err_timeout (inter-byte timeout pulse).
// Optional: define SEQ_BYTE_TIMEOUT_EN to abandon a half-received sample after
//           TIMEOUT_CYCLES idle cycles in WAIT_LSB; otherwise err_timeout is 0.
module spike_sample_sequencer
  import spike_seq_pkg::*;
#(
  parameter int unsigned NUM_UNITS      = 2,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PROCESS_CYCLES = 2,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  input  logic                   frame_start,
  output logic                   byte_ready,
  output logic [DATA_WIDTH-1:0]  sample_data,
  output logic [NUM_UNITS-1:0]   unit_valid,
  input  logic [NUM_UNITS-1:0]   unit_spike,
  input  logic [2*NUM_UNITS-1:0] unit_event,
  output logic                   res_valid,
  output logic [1:0]             res_unit,
  output logic                   res_spike,
  output logic [1:0]             res_event,
  input  logic [1:0]             cnt_sel,
  output logic [CNT_WIDTH-1:0]   cnt_out,
  input  logic                   clr,
  output logic                   overrun,
  output logic                   err_timeout
);

  localparam int unsigned PCW = $clog2(PROCESS_CYCLES + 1);

  // Elaboration-time parameter sanity
  if (NUM_UNITS < 1 || NUM_UNITS > 4) begin : g_bad_units
    $error("NUM_UNITS must be 1..4");
  end
  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("DATA_WIDTH must be 16");
  end
  if (PROCESS_CYCLES < 1) begin : g_bad_proc
    $error("PROCESS_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  seq_state_e           state_q;
  unit_idx_t            ch_q;
  logic [7:0]           msb_q;
  logic [PCW-1:0]       proc_q;
  logic                 fs_pend_q;
  seq_result_t          res_q;

  logic                 sel_spike_c;
  logic [EVENT_W-1:0]   sel_event_c;
  logic [NUM_UNITS-1:0] ch_onehot_c;
  logic [NUM_UNITS-1:0] inc_c;

  // Current unit's result lines and one-hot strobe
  always_comb begin
    sel_spike_c = 1'(unit_spike >> ch_q);
    sel_event_c = EVENT_W'(unit_event >> {ch_q, 1'b0});
    ch_onehot_c = NUM_UNITS'(1) << ch_q;
  end

  // Count the captured spike while the result is presented
  assign inc_c = ((state_q == CAPTURE) && res_q.spike) ? ch_onehot_c : '0;

  assign res_unit  = res_q.unit;
  assign res_spike = res_q.spike;
  assign res_event = res_q.evt;

`ifdef SEQ_BYTE_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0] to_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_MSB;
      ch_q        <= '0;
      msb_q       <= '0;
      proc_q      <= '0;
      fs_pend_q   <= 1'b0;
      res_q       <= '{unit: '0, spike: 1'b0, evt: EV_NONE};
      byte_ready  <= 1'b1;
      sample_data <= '0;
      unit_valid  <= '0;
      res_valid   <= 1'b0;
      overrun     <= 1'b0;
`ifdef SEQ_BYTE_TIMEOUT_EN
      to_q        <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      unit_valid <= '0;
      res_valid  <= 1'b0;
`ifdef SEQ_BYTE_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
      if (clr) begin
        overrun <= 1'b0;
      end else if (byte_valid && !byte_ready) begin
        overrun <= 1'b1;
      end

      case (state_q)
        WAIT_MSB: begin
          if (frame_start) ch_q <= '0;
          if (byte_valid) begin
            msb_q   <= byte_in;
            state_q <= WAIT_LSB;
`ifdef SEQ_BYTE_TIMEOUT_EN
            to_q    <= '0;
`endif
          end
        end

        WAIT_LSB: begin
          // frame_start drops the held MSB; a same-cycle byte restarts as MSB
          if (frame_start) begin
            ch_q <= '0;
            if (byte_valid) begin
              msb_q <= byte_in;
`ifdef SEQ_BYTE_TIMEOUT_EN
              to_q  <= '0;
`endif
            end else begin
              state_q <= WAIT_MSB;
            end
          end else if (byte_valid) begin
            sample_data <= DATA_WIDTH'({msb_q, byte_in});
            unit_valid  <= ch_onehot_c;
            byte_ready  <= 1'b0;
            proc_q      <= '0;
            state_q     <= ISSUE;
          end
`ifdef SEQ_BYTE_TIMEOUT_EN
          else if (to_q == TOW'(TIMEOUT_CYCLES - 1)) begin
            err_timeout <= 1'b1;
            state_q     <= WAIT_MSB;
          end else begin
            to_q <= to_q + TOW'(1);
          end
`endif
        end

        ISSUE: begin
          if (frame_start) fs_pend_q <= 1'b1;
          state_q <= PROCESS;
        end

        PROCESS: begin
          if (frame_start) fs_pend_q <= 1'b1;
          if (proc_q == PCW'(PROCESS_CYCLES - 1)) begin
            res_valid <= 1'b1;
            res_q     <= '{unit: ch_q, spike: sel_spike_c, evt: sel_event_c};
            state_q   <= CAPTURE;
          end else begin
            proc_q <= proc_q + PCW'(1);
          end
        end

        CAPTURE: begin
          ch_q       <= (fs_pend_q || frame_start) ? '0 : next_unit(ch_q, NUM_UNITS);
          fs_pend_q  <= 1'b0;
          byte_ready <= 1'b1;
          state_q    <= WAIT_MSB;
        end

        default: begin
          state_q    <= WAIT_MSB;
          byte_ready <= 1'b1;
        end
      endcase
    end
  end

  spike_counter_bank #(
    .NUM_UNITS (NUM_UNITS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .inc     (inc_c),
    .sel     (cnt_sel),
    .cnt_out (cnt_out)
  );

endmodule

// File: tb/tb_spike_sample_sequencer.sv
// Self-checking bench for spike_sample_sequencer: vector table, directed
// corner sequences and randomized samples against a behavioural model.
module tb_spike_sample_sequencer;

  localparam int NU = 2;
  localparam int PC = 2;
  localparam int CW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          byte_ready;
  logic [15:0]   sample_data;
  logic [NU-1:0] unit_valid;
  logic [NU-1:0] unit_spike = '0;
  logic [2*NU-1:0] unit_event = '0;
  logic          res_valid;
  logic [1:0]    res_unit;
  logic          res_spike;
  logic [1:0]    res_event;
  logic [1:0]    cnt_sel = '0;
  logic [CW-1:0] cnt_out;
  logic          clr = 1'b0;
  logic          overrun;
  logic          err_timeout;

  always #5 clk = ~clk;

  spike_sample_sequencer #(
    .NUM_UNITS(NU), .DATA_WIDTH(16), .PROCESS_CYCLES(PC),
    .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .frame_start(frame_start), .byte_ready(byte_ready), .sample_data(sample_data),
    .unit_valid(unit_valid), .unit_spike(unit_spike), .unit_event(unit_event),
    .res_valid(res_valid), .res_unit(res_unit), .res_spike(res_spike),
    .res_event(res_event), .cnt_sel(cnt_sel), .cnt_out(cnt_out), .clr(clr),
    .overrun(overrun), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [NU-1:0] uv;
    logic [15:0]   sample;
    logic          ready;
    int            lat;
    logic [1:0]    unit;
    logic          spike;
    logic [1:0]    evt;
  } obs_t;

  typedef struct {
    logic [7:0]      msb;
    logic [7:0]      lsb;
    logic [NU-1:0]   sp;
    logic [2*NU-1:0] ev;
    logic [NU-1:0]   e_uv;
    logic [15:0]     e_sample;
    logic [1:0]      e_unit;
    logic            e_spike;
    logic [1:0]      e_event;
    logic [CW-1:0]   e_cnt0;
    logic [CW-1:0]   e_cnt1;
  } vec_t;

  vec_t tbl [5];

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: next unit, spike counts
  int m_ch = 0;
  int m_cnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in the cycle after the LSB edge; follows the sample to its result
  task automatic finish_sample(input logic [NU-1:0] sp, input logic [2*NU-1:0] ev,
                               input int junk_at, input int fs_at, input int clr_at,
                               output obs_t o);
    byte_valid = 1'b0;
    unit_spike = sp;
    unit_event = ev;
    o.uv     = unit_valid;
    o.sample = sample_data;
    o.ready  = byte_ready;
    o.lat    = 1;
    while (!res_valid && o.lat < 20) begin
      byte_valid  = (o.lat == junk_at);
      byte_in     = 8'hEE;
      frame_start = (o.lat == fs_at);
      step();
      o.lat++;
    end
    byte_valid  = 1'b0;
    frame_start = 1'b0;
    o.unit  = res_unit;
    o.spike = res_spike;
    o.evt   = res_event;
    clr = (o.lat == clr_at);
    step();
    clr = 1'b0;
  endtask

  task automatic run_sample(input logic [7:0] msb, input logic [7:0] lsb,
                            input logic [NU-1:0] sp, input logic [2*NU-1:0] ev,
                            input int junk_at, input int fs_at, input int clr_at,
                            output obs_t o);
    byte_valid = 1'b1;
    byte_in    = msb;
    step();
    byte_in = lsb;
    step();
    finish_sample(sp, ev, junk_at, fs_at, clr_at, o);
  endtask

  task automatic model_check(input string tag, input obs_t o, input logic [15:0] samp,
                             input logic [NU-1:0] sp, input logic [2*NU-1:0] ev,
                             input bit fs, input bit clr_hit);
    logic [NU-1:0] e_uv;
    logic [2*NU-1:0] evs;
    e_uv = '0;
    e_uv[m_ch] = 1'b1;
    evs = ev >> (2 * m_ch);
    chk({tag, " unit_valid"}, 32'(o.uv), 32'(e_uv));
    chk({tag, " sample"}, 32'(o.sample), 32'(samp));
    chk({tag, " ready"}, 32'(o.ready), 32'h0);
    chk({tag, " latency"}, o.lat, PC + 2);
    chk({tag, " res_unit"}, 32'(o.unit), m_ch);
    chk({tag, " res_spike"}, 32'(o.spike), 32'(sp[m_ch]));
    chk({tag, " res_event"}, 32'(o.evt), 32'(evs[1:0]));
    if (clr_hit) begin
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end else if (sp[m_ch] && m_cnt[m_ch] < (2 ** CW) - 1) begin
      m_cnt[m_ch]++;
    end
    m_ch = fs ? 0 : (m_ch + 1) % NU;
  endtask

  task automatic check_counters(input string tag);
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      chk($sformatf("%s cnt%0d", tag, s), 32'(cnt_out), (s < NU) ? m_cnt[s] : 0);
    end
    cnt_sel = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    logic [7:0] rm, rl;
    logic [NU-1:0] rsp;
    logic [2*NU-1:0] rev;
    bit rfs;
    int pulses, first_pulse, seen;

    tbl[0] = '{8'h12, 8'h34, 2'b01, 4'b0010, 2'b01, 16'h1234, 2'd0, 1'b1, 2'b10, 8'd1, 8'd0};
    tbl[1] = '{8'h56, 8'h78, 2'b10, 4'b0100, 2'b10, 16'h5678, 2'd1, 1'b1, 2'b01, 8'd1, 8'd1};
    tbl[2] = '{8'h9A, 8'hBC, 2'b10, 4'b1100, 2'b01, 16'h9ABC, 2'd0, 1'b0, 2'b00, 8'd1, 8'd1};
    tbl[3] = '{8'hDE, 8'hF0, 2'b01, 4'b1101, 2'b10, 16'hDEF0, 2'd1, 1'b0, 2'b11, 8'd1, 8'd1};
    tbl[4] = '{8'h00, 8'hFF, 2'b11, 4'b0011, 2'b01, 16'h00FF, 2'd0, 1'b1, 2'b11, 8'd2, 8'd1};
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst byte_ready", 32'(byte_ready), 32'h1);
    chk("rst unit_valid", 32'(unit_valid), 32'h0);
    chk("rst res_valid", 32'(res_valid), 32'h0);
    chk("rst sample_data", 32'(sample_data), 32'h0);
    chk("rst overrun", 32'(overrun), 32'h0);
    chk("rst err_timeout", 32'(err_timeout), 32'h0);
    chk("rst cnt_out", 32'(cnt_out), 32'h0);
    rst_n = 1'b1;
    step();

    // Vector table: round-robin wrap, result capture, counting
    for (int i = 0; i < 5; i++) begin
      run_sample(tbl[i].msb, tbl[i].lsb, tbl[i].sp, tbl[i].ev, 0, 0, 0, o);
      chk($sformatf("tbl%0d unit_valid", i), 32'(o.uv), 32'(tbl[i].e_uv));
      chk($sformatf("tbl%0d sample", i), 32'(o.sample), 32'(tbl[i].e_sample));
      chk($sformatf("tbl%0d latency", i), o.lat, PC + 2);
      chk($sformatf("tbl%0d res_unit", i), 32'(o.unit), 32'(tbl[i].e_unit));
      chk($sformatf("tbl%0d res_spike", i), 32'(o.spike), 32'(tbl[i].e_spike));
      chk($sformatf("tbl%0d res_event", i), 32'(o.evt), 32'(tbl[i].e_event));
      cnt_sel = 2'd0;
      #1;
      chk($sformatf("tbl%0d cnt0", i), 32'(cnt_out), 32'(tbl[i].e_cnt0));
      cnt_sel = 2'd1;
      #1;
      chk($sformatf("tbl%0d cnt1", i), 32'(cnt_out), 32'(tbl[i].e_cnt1));
      cnt_sel = 2'd0;
    end
    m_ch = 1;
    m_cnt[0] = 2;
    m_cnt[1] = 1;
    check_counters("after table");

    // frame_start with a same-cycle byte discards the held MSB
    byte_valid = 1'b1;
    byte_in = 8'hAB;
    step();
    frame_start = 1'b1;
    byte_in = 8'h01;
    step();
    frame_start = 1'b0;
    byte_in = 8'h02;
    step();
    m_ch = 0;
    finish_sample(2'b00, 4'b0000, 0, 0, 0, o);
    model_check("fs discard", o, 16'h0102, 2'b00, 4'b0000, 1'b0, 1'b0);

    // Byte offered during PROCESS is dropped and flagged
    chk("pre overrun", 32'(overrun), 32'h0);
    run_sample(8'h31, 8'h41, 2'b11, 4'b0110, 2, 0, 0, o);
    model_check("overrun smp", o, 16'h3141, 2'b11, 4'b0110, 1'b0, 1'b0);
    chk("overrun set", 32'(overrun), 32'h1);
    run_sample(8'h59, 8'h26, 2'b00, 4'b1001, 0, 0, 0, o);
    model_check("after drop", o, 16'h5926, 2'b00, 4'b1001, 1'b0, 1'b0);
    chk("overrun sticky", 32'(overrun), 32'h1);
    check_counters("before clr");
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    chk("clr overrun", 32'(overrun), 32'h0);
    check_counters("after clr");

    // frame_start during PROCESS takes effect at CAPTURE
    run_sample(8'h11, 8'h22, 2'b00, 4'b0000, 0, 0, 0, o);
    model_check("pre pend", o, 16'h1122, 2'b00, 4'b0000, 1'b0, 1'b0);
    run_sample(8'h33, 8'h44, 2'b10, 4'b1000, 0, 2, 0, o);
    model_check("pend fs", o, 16'h3344, 2'b10, 4'b1000, 1'b1, 1'b0);

    // Randomized samples against the model
    for (int i = 0; i < 40; i++) begin
      rm  = 8'($urandom);
      rl  = 8'($urandom);
      rsp = NU'($urandom);
      rev = (2 * NU)'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        m_ch = 0;
      end
      rfs = ($urandom_range(0, 4) == 0);
      run_sample(rm, rl, rsp, rev, 0, rfs ? 2 : 0, 0, o);
      model_check($sformatf("rnd%0d", i), o, {rm, rl}, rsp, rev, rfs, 1'b0);
      if (i % 10 == 9) check_counters($sformatf("rnd%0d", i));
    end

    // Saturation on unit 0, then clr racing a CAPTURE increment
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    m_ch = 0;
    for (int i = 0; i < 300; i++) begin
      run_sample(8'h55, 8'hAA, 2'b01, 4'b0000, 0, 2, 0, o);
      model_check("sat", o, 16'h55AA, 2'b01, 4'b0000, 1'b1, 1'b0);
    end
    cnt_sel = 2'd0;
    #1;
    chk("saturated cnt0", 32'(cnt_out), 32'd255);
    run_sample(8'h66, 8'h77, 2'b01, 4'b0000, 0, 2, PC + 2, o);
    model_check("clr race", o, 16'h6677, 2'b01, 4'b0000, 1'b1, 1'b1);
    cnt_sel = 2'd0;
    #1;
    chk("clr wins cnt0", 32'(cnt_out), 32'd0);

    // Unpopulated counter selects read zero
    run_sample(8'h01, 8'h01, 2'b01, 4'b0000, 0, 0, 0, o);
    model_check("sel pre", o, 16'h0101, 2'b01, 4'b0000, 1'b0, 1'b0);
    check_counters("sel range");

    // Reset mid-sample: immediate return, no result for the aborted sample
    unit_spike = 2'b11;
    byte_valid = 1'b1;
    byte_in = 8'h99;
    step();
    byte_in = 8'h88;
    step();
    byte_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst byte_ready", 32'(byte_ready), 32'h1);
    chk("midrst sample", 32'(sample_data), 32'h0);
    cnt_sel = 2'd0;
    #1;
    chk("midrst cnt0", 32'(cnt_out), 32'h0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) seen++;
      step();
    end
    chk("midrst no result", seen, 0);
    m_ch = 0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    run_sample(8'hC3, 8'h3C, 2'b01, 4'b0001, 0, 0, 0, o);
    model_check("post rst", o, 16'hC33C, 2'b01, 4'b0001, 1'b0, 1'b0);

`ifdef SEQ_BYTE_TIMEOUT_EN
    // MSB then TO idle cycles: timeout pulse, channel kept
    byte_valid = 1'b1;
    byte_in = 8'h77;
    step();
    byte_valid = 1'b0;
    pulses = 0;
    first_pulse = -1;
    for (int i = 1; i <= TO + 4; i++) begin
      if (err_timeout) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
      step();
    end
    chk("timeout pulse count", pulses, 1);
    chk("timeout pulse cycle", first_pulse, TO + 1);
    run_sample(8'h12, 8'h34, 2'b00, 4'b0000, 0, 0, 0, o);
    model_check("after timeout", o, 16'h1234, 2'b00, 4'b0000, 1'b0, 1'b0);
    // LSB on the expiry cycle is accepted
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    step();
    byte_valid = 1'b0;
    repeat (TO - 1) step();
    byte_valid = 1'b1;
    byte_in = 8'hA5;
    step();
    chk("expiry no err", 32'(err_timeout), 32'h0);
    finish_sample(2'b00, 4'b0000, 0, 0, 0, o);
    model_check("expiry lsb", o, 16'h5AA5, 2'b00, 4'b0000, 1'b0, 1'b0);
`else
    // Without the timeout, WAIT_LSB waits indefinitely
    byte_valid = 1'b1;
    byte_in = 8'h77;
    step();
    byte_valid = 1'b0;
    pulses = 0;
    first_pulse = -1;
    for (int i = 1; i <= TO + 40; i++) begin
      if (err_timeout) pulses++;
      step();
    end
    chk("no timeout pulses", pulses, 0);
    byte_valid = 1'b1;
    byte_in = 8'h88;
    step();
    finish_sample(2'b00, 4'b0000, 0, 0, 0, o);
    model_check("long wait", o, 16'h7788, 2'b00, 4'b0000, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
